// File: rtl/memory_cycle_hs_if.sv
// ---------------------------------------------------------------------------
// memory_cycle_hs_if
// Bundles every signal that crosses the MEM stage boundary except clk/rst:
//   - E/M pipeline register fields coming from execute (RegWriteM .. PCPlus4M)
//   - data-memory req/ack handshake (dmem_req/we/addr/wdata, dmem_rdata/ack)
//   - pipeline control back to upstream (StallM)
//   - M/W pipeline register fields going to writeback (RegWriteW .. PCPlus4W)
//   - sticky error flag (mem_err)
// modport master : the MEM stage itself
// modport slave  : its environment (execute stage, data memory, writeback)
// ---------------------------------------------------------------------------
interface memory_cycle_hs_if;
  logic        RegWriteM;
  logic        ResultSrcM;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [4:0]  RdM;
  logic [31:0] PCPlus4M;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  logic        StallM;

  logic        RegWriteW;
  logic        ResultSrcW;
  logic [4:0]  RdW;
  logic [31:0] ReadDataW;
  logic [31:0] ALUResultW;
  logic [31:0] PCPlus4W;

  logic        mem_err;

  modport master (
    input  RegWriteM, ResultSrcM, MemWriteM, ALUResultM, WriteDataM, RdM, PCPlus4M,
    input  dmem_rdata, dmem_ack,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output StallM,
    output RegWriteW, ResultSrcW, RdW, ReadDataW, ALUResultW, PCPlus4W,
    output mem_err
  );

  modport slave (
    output RegWriteM, ResultSrcM, MemWriteM, ALUResultM, WriteDataM, RdM, PCPlus4M,
    output dmem_rdata, dmem_ack,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  StallM,
    input  RegWriteW, ResultSrcW, RdW, ReadDataW, ALUResultW, PCPlus4W,
    input  mem_err
  );
endinterface

// File: rtl/memory_cycle_hs.sv
// ---------------------------------------------------------------------------
// memory_cycle_hs
// MEM stage of the 5-stage RISC-V pipeline. Issues word loads/stores to a
// variable-latency data memory over a req/ack handshake, stalls upstream
// while an access is outstanding, aborts on misalignment or timeout (setting
// a sticky error flag) and registers the results into the M/W register.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous, active-low reset
//   bus  - memory_cycle_hs_if.master (E/M inputs, dmem handshake, StallM,
//          M/W outputs, mem_err)
// Parameters:
//   TIMEOUT - max cycles in WAIT before abort (0 disables the timeout)
//   CNT_W   - wait counter width, 2**CNT_W must exceed TIMEOUT
// ---------------------------------------------------------------------------
module memory_cycle_hs #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  memory_cycle_hs_if.master bus
);

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic             TIMEOUT_EN = (TIMEOUT != 0);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             memErr_q;

  logic             regWriteW_q;
  logic             resultSrcW_q;
  logic [4:0]       rdW_q;
  logic [31:0]      readDataW_q;
  logic [31:0]      aluResultW_q;
  logic [31:0]      pcPlus4W_q;

  logic             need;
  logic             mis;
  logic             timeout;
  logic             abort;
  logic             req;
  logic             stall;

  // Handshake decode. req and stall are gated by rst so that a reset landing
  // mid-access drops the request at once instead of waiting for a clock edge.
  always_comb begin
    need    = bus.MemWriteM | bus.ResultSrcM;
    mis     = need & (bus.ALUResultM[1:0] != 2'b00);
    // cnt equals the number of cycles since the request was first raised, so
    // hitting TIMEOUT here means the access has been outstanding that long.
    timeout = (state_q == ST_WAIT) & TIMEOUT_EN & (cnt_q == TIMEOUT_C) & ~bus.dmem_ack;
    abort   = (mis & (state_q == ST_IDLE)) | timeout;
    req     = rst & need & ~mis & ~abort;
    stall   = rst & need & ~bus.dmem_ack & ~abort;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (req & ~bus.dmem_ack) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      ST_WAIT: begin
        // An ack in the timeout cycle suppresses 'timeout', so ack wins.
        if (bus.dmem_ack | timeout) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      memErr_q <= 1'b0;
    end else if (abort) begin
      memErr_q <= 1'b1;
    end
  end

  // M/W register: held (not bubbled) while stalled; an aborted access still
  // advances but must not write the register file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regWriteW_q  <= 1'b0;
      resultSrcW_q <= 1'b0;
      rdW_q        <= '0;
      readDataW_q  <= '0;
      aluResultW_q <= '0;
      pcPlus4W_q   <= '0;
    end else if (!stall) begin
      regWriteW_q  <= bus.RegWriteM & ~abort;
      resultSrcW_q <= bus.ResultSrcM;
      rdW_q        <= bus.RdM;
      readDataW_q  <= (bus.ResultSrcM & bus.dmem_ack & ~abort) ? bus.dmem_rdata : 32'h0;
      aluResultW_q <= bus.ALUResultM;
      pcPlus4W_q   <= bus.PCPlus4M;
    end
  end

  assign bus.dmem_req   = req;
  assign bus.dmem_we    = bus.MemWriteM;
  assign bus.dmem_addr  = bus.ALUResultM;
  assign bus.dmem_wdata = bus.WriteDataM;
  assign bus.StallM     = stall;
  assign bus.RegWriteW  = regWriteW_q;
  assign bus.ResultSrcW = resultSrcW_q;
  assign bus.RdW        = rdW_q;
  assign bus.ReadDataW  = readDataW_q;
  assign bus.ALUResultW = aluResultW_q;
  assign bus.PCPlus4W   = pcPlus4W_q;
  assign bus.mem_err    = memErr_q;

endmodule

// File: doc/memory_cycle_hs.md
Name: memory_cycle_hs

Overview:
- MEM stage of the 5-stage RISC-V pipeline. It sits directly downstream of the execute stage and consumes its M-side pipeline register outputs.
- Performs word loads and stores through a req/ack handshake to a variable-latency data memory, and stalls upstream while an access is outstanding.
- Aborts on timeout or misalignment and sets a sticky error flag.
- Registers results into the M/W pipeline register that feeds writeback.

Parameters:
- TIMEOUT, 16: maximum cycles in WAIT before abort; 0 disables the timeout.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- RegWriteM  input  1  instruction writes the register file.
- ResultSrcM  input  1  1 = load (result from memory), 0 = ALU result.
- MemWriteM  input  1  store.
- ALUResultM  input  32  effective address, or ALU result.
- WriteDataM  input  32  store data.
- RdM  input  5  destination register.
- PCPlus4M  input  32  PC+4 of the instruction.
- dmem_req  output  1  access request.
- dmem_we  output  1  1 = write.
- dmem_addr  output  32  byte address (equals ALUResultM).
- dmem_wdata  output  32  equals WriteDataM.
- dmem_rdata  input  32  load data, valid when dmem_ack=1.
- dmem_ack  input  1  access complete, same-cycle response allowed.
- StallM  output  1  freezes the PC, F/D, D/E and E/M registers.
- RegWriteW  output  1  registered.
- ResultSrcW  output  1  registered.
- RdW  output  5  registered.
- ReadDataW  output  32  registered.
- ALUResultW  output  32  registered.
- PCPlus4W  output  32  registered.
- mem_err  output  1  sticky error flag.

Behaviour:
- Access is needed when need = MemWriteM | ResultSrcM.
- Misalignment: mis = need & (ALUResultM[1:0] != 0).
- Reset (rst=0, async): state=IDLE, cnt=0, mem_err=0, all W outputs 0.
- The E/M inputs are held stable by upstream while StallM=1.
- dmem_req = need & ~mis & ~abort.
  - Combinational.
  - Held high continuously until the cycle in which dmem_ack=1.
- dmem_we = MemWriteM; dmem_addr = ALUResultM; dmem_wdata = WriteDataM. All combinational.
- FSM states:
  - IDLE:
    - if dmem_req & ~dmem_ack, go to WAIT with cnt=1;
    - otherwise stay in IDLE (zero-wait access, no stall).
  - WAIT:
    - cnt increments each cycle;
    - on dmem_ack, go to IDLE with cnt=0;
    - on timeout, go to IDLE with cnt=0 and abort.
- abort is asserted when either condition holds:
  - mis=1, in IDLE, same cycle;
  - state=WAIT & TIMEOUT!=0 & cnt==TIMEOUT & ~dmem_ack.
- StallM = need & ~dmem_ack & ~abort.
  - Latency = ack cycle − request cycle.
  - Stall cycles = that latency.
- W register on posedge clk:
  - StallM=1: hold all W outputs (no bubble). The regfile rewrite is idempotent and W forwarding stays valid.
  - StallM=0 and normal completion:
    - RegWriteW=RegWriteM, ResultSrcW=ResultSrcM, RdW=RdM, ALUResultW=ALUResultM, PCPlus4W=PCPlus4M.
    - ReadDataW = dmem_rdata if ResultSrcM & dmem_ack, else 0.
  - StallM=0 and abort:
    - RegWriteW=0 and ReadDataW=0;
    - all other fields copied as normal.
- mem_err is set on any abort and cleared only by reset.
- ack in the same cycle as the timeout: ack wins, no abort.
- dmem_ack while need=0 (spurious): ignored; no state change and no effect on ReadDataW.
- Non-memory instruction (need=0): passes in 1 cycle; dmem_req=0.
- Reset asserted mid-WAIT: returns to IDLE immediately and drops dmem_req. The memory must discard the outstanding access.
- Back-to-back accesses: a new request may be asserted in the cycle after ack, when the E/M register has advanced.

Test Plan:
- Reset with rst=0 while RegWriteM=1 → all W outputs 0, mem_err=0, StallM=0; after release, first edge W follows inputs.
- ALU op: RegWriteM=1, RdM=5, ALUResultM=0x0000_00A5, mem ack idle → dmem_req=0, StallM=0; next edge RdW=5, ALUResultW=0xA5, RegWriteW=1.
- Load at 0x100, ack same cycle with rdata 0xDEAD_BEEF → no stall; next edge ReadDataW=0xDEADBEEF, ResultSrcW=1.
- Store at 0x204, data 0x1234_5678, ack after 3 cycles:
  - StallM=1 for exactly 3 cycles;
  - dmem_req, dmem_we, addr and wdata stable throughout;
  - W outputs held;
  - W updates on the ack edge.
- Load at 0x300, no ack, TIMEOUT=16:
  - StallM=1 for 16 cycles, then drops;
  - W gets RegWriteW=0, ReadDataW=0;
  - mem_err=1 and remains 1 after later successful accesses.
- Misaligned load at 0x102 → dmem_req never asserted, no stall, RegWriteW=0, mem_err=1. Separately, rst pulsed low during WAIT → state IDLE, dmem_req=0 immediately.
